// File: rtl/bc_msg_arbiter.sv
// Round-robin broadcast message arbiter: serialises per-core message ports into one
// registered broadcast stream, drains disabled ports, and keeps sent/dropped counters.
module bc_msg_arbiter #(
    parameter int CORE_COUNT    = 16,
    parameter int MSG_WIDTH     = 46,
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_bc_msg,
    input  logic [CORE_COUNT-1:0]           s_bc_msg_valid,
    output logic [CORE_COUNT-1:0]           s_bc_msg_ready,
    input  logic [CORE_COUNT-1:0]           port_enable,
    output logic [MSG_WIDTH-1:0]            m_bc_msg,
    output logic                            m_bc_msg_valid,
    output logic [CORE_ID_WIDTH-1:0]        m_bc_msg_src,
    output logic [31:0]                     bc_msg_count,
    output logic [15:0]                     bc_drop_count
);

    localparam int POP_W = $clog2(CORE_COUNT + 1);

    logic [CORE_COUNT-1:0]    req;
    logic [CORE_COUNT-1:0]    grant;
    logic [CORE_COUNT-1:0]    drain;
    logic [CORE_ID_WIDTH-1:0] cand;
    logic [CORE_ID_WIDTH-1:0] grant_idx;
    logic                     grant_vld;
    logic [POP_W-1:0]         drop_pop;
    logic [16:0]              drop_sum;

    logic [MSG_WIDTH-1:0]     msg_q, msg_d;
    logic                     vld_q, vld_d;
    logic [CORE_ID_WIDTH-1:0] src_q, src_d;
    logic [CORE_ID_WIDTH-1:0] last_q, last_d;
    logic [31:0]              msg_cnt_q, msg_cnt_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;

    assign req   = s_bc_msg_valid & port_enable;
    assign drain = s_bc_msg_valid & ~port_enable;

    // Search starts one past the last granted port so every requester waits at most N-1 grants.
    always_comb begin
        cand      = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 1; k <= CORE_COUNT; k++) begin
            cand = CORE_ID_WIDTH'((int'(last_q) + k) % CORE_COUNT);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    assign s_bc_msg_ready = rst ? '0 : (grant | ~port_enable);

    always_comb begin
        drop_pop = '0;
        for (int i = 0; i < CORE_COUNT; i++) drop_pop = drop_pop + POP_W'(drain[i]);
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_pop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        msg_d     = msg_q;
        src_d     = src_q;
        last_d    = last_q;
        vld_d     = grant_vld;
        msg_cnt_d = msg_cnt_q;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (grant[i]) msg_d = s_bc_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end
        if (grant_vld) begin
            src_d     = grant_idx;
            last_d    = grant_idx;
            msg_cnt_d = msg_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q      <= '0;
            vld_q      <= 1'b0;
            src_q      <= '0;
            last_q     <= CORE_ID_WIDTH'(CORE_COUNT - 1);
            msg_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            msg_q      <= msg_d;
            vld_q      <= vld_d;
            src_q      <= src_d;
            last_q     <= last_d;
            msg_cnt_q  <= msg_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m_bc_msg       = msg_q;
    assign m_bc_msg_valid = vld_q;
    assign m_bc_msg_src   = src_q;
    assign bc_msg_count   = msg_cnt_q;
    assign bc_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Self-checking bench for bc_msg_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-free round-robin reference model.
module tb_bc_msg_arbiter;

    localparam int N  = 16;
    localparam int MW = 46;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*MW-1:0]   s_bc_msg = '0;
    logic [N-1:0]      s_bc_msg_valid = '0;
    logic [N-1:0]      s_bc_msg_ready;
    logic [N-1:0]      port_enable = '1;
    logic [MW-1:0]     m_bc_msg;
    logic              m_bc_msg_valid;
    logic [IW-1:0]     m_bc_msg_src;
    logic [31:0]       bc_msg_count;
    logic [15:0]       bc_drop_count;

    bc_msg_arbiter #(.CORE_COUNT(N), .MSG_WIDTH(MW), .CORE_ID_WIDTH(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_bc_msg       (s_bc_msg),
        .s_bc_msg_valid (s_bc_msg_valid),
        .s_bc_msg_ready (s_bc_msg_ready),
        .port_enable    (port_enable),
        .m_bc_msg       (m_bc_msg),
        .m_bc_msg_valid (m_bc_msg_valid),
        .m_bc_msg_src   (m_bc_msg_src),
        .bc_msg_count   (bc_msg_count),
        .bc_drop_count  (bc_drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [MW-1:0] data [N];

    // Reference model state
    int            m_last;
    logic [MW-1:0] m_msg;
    logic          m_valid;
    int            m_src;
    logic [31:0]   m_cnt;
    int            m_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_msg   = '0;
        m_valid = 1'b0;
        m_src   = 0;
        m_cnt   = '0;
        m_drop  = 0;
    endtask

    // One clock: drive at current (negedge) time, check ready, step clock, check outputs.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] en, input string tag);
        int g;
        logic [N-1:0] exp_rdy;
        for (int i = 0; i < N; i++) s_bc_msg[i*MW +: MW] = data[i];
        s_bc_msg_valid = v;
        port_enable    = en;
        #1;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && v[(m_last + k) % N] && en[(m_last + k) % N]) g = (m_last + k) % N;
        end
        exp_rdy = ~en;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ".ready"}, 64'(s_bc_msg_ready), 64'(exp_rdy));
        @(posedge clk);
        if (g >= 0) begin
            m_msg   = data[g];
            m_valid = 1'b1;
            m_src   = g;
            m_last  = g;
            m_cnt   = m_cnt + 32'd1;
        end else begin
            m_valid = 1'b0;
        end
        m_drop = m_drop + $countones(v & ~en);
        if (m_drop > 65535) m_drop = 65535;
        #1;
        chk({tag, ".valid"}, 64'(m_bc_msg_valid), 64'(m_valid));
        chk({tag, ".msg"},   64'(m_bc_msg),       64'(m_msg));
        chk({tag, ".src"},   64'(m_bc_msg_src),   64'(m_src));
        chk({tag, ".cnt"},   64'(bc_msg_count),   64'(m_cnt));
        chk({tag, ".drop"},  64'(bc_drop_count),  64'(m_drop));
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) data[i] = {$urandom, $urandom};
    endtask

    // Asynchronous reset asserted between clock edges, with disabled valid ports present.
    task automatic mid_reset(input string tag);
        s_bc_msg_valid = '1;
        port_enable    = '0;
        #2 rst = 1'b1;
        #1;
        chk({tag, ".rst_ready"}, 64'(s_bc_msg_ready), 64'd0);
        chk({tag, ".rst_valid"}, 64'(m_bc_msg_valid), 64'd0);
        chk({tag, ".rst_msg"},   64'(m_bc_msg),       64'd0);
        chk({tag, ".rst_src"},   64'(m_bc_msg_src),   64'd0);
        chk({tag, ".rst_cnt"},   64'(bc_msg_count),   64'd0);
        chk({tag, ".rst_drop"},  64'(bc_drop_count),  64'd0);
        @(negedge clk);
        s_bc_msg_valid = '0;
        port_enable    = '1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < N; i++) data[i] = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset and idle
        mid_reset("reset0");
        for (int c = 0; c < 3; c++) cycle('0, '1, "idle");

        // Single message from port 3
        data[3] = 46'h1_2345_6789;
        cycle(16'h0008, '1, "single");
        chk("single.src3", 64'(m_bc_msg_src), 64'd3);
        chk("single.cnt1", 64'(bc_msg_count), 64'd1);
        cycle('0, '1, "single_after");

        // Full contention: rotation 0..15 twice
        mid_reset("reset1");
        for (int c = 0; c < 32; c++) begin
            rand_data();
            cycle('1, '1, "contend");
            chk("contend.rot", 64'(m_bc_msg_src), 64'(c % N));
        end
        chk("contend.cnt32", 64'(bc_msg_count), 64'd32);

        // Back-to-back single requester, then pointer skip past 5
        for (int c = 0; c < 4; c++) begin
            rand_data();
            cycle(16'h0020, '1, "b2b");
            chk("b2b.src5", 64'(m_bc_msg_src), 64'd5);
        end
        rand_data();
        cycle(16'h0204, '1, "skip");
        chk("skip.src9", 64'(m_bc_msg_src), 64'd9);
        cycle(16'h0004, '1, "skip");
        chk("skip.src2", 64'(m_bc_msg_src), 64'd2);

        // Drain port 7 while port 1 streams
        mid_reset("reset2");
        for (int c = 0; c < 10; c++) begin
            rand_data();
            cycle(16'h0082, 16'hFF7F, "drain");
            chk("drain.src1", 64'(m_bc_msg_src), 64'd1);
        end
        chk("drain.drop10", 64'(bc_drop_count), 64'd10);
        chk("drain.cnt10",  64'(bc_msg_count),  64'd10);

        // Random traffic with random enables
        for (int c = 0; c < 300; c++) begin
            rand_data();
            cycle(N'($urandom), N'($urandom | $urandom), "random");
        end

        // Drop counter saturation
        mid_reset("reset3");
        for (int c = 0; c < 4095; c++) cycle('1, '0, "satfill");
        cycle(16'h3FFF, '0, "satfill");
        chk("sat.fffe", 64'(bc_drop_count), 64'hFFFE);
        cycle(16'h0003, '0, "sat");
        chk("sat.ffff", 64'(bc_drop_count), 64'hFFFF);
        cycle(16'h0003, '0, "sat");
        chk("sat.hold", 64'(bc_drop_count), 64'hFFFF);

        // Message counter wrap from all-ones
        force dut.msg_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.msg_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        chk("wrap.preload", 64'(bc_msg_count), 64'hFFFF_FFFF);
        rand_data();
        cycle(16'h0400, '1, "wrap");
        chk("wrap.zero", 64'(bc_msg_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
